// File: rtl/fir_stream.sv
// Purpose : streaming direct-form FIR filter with a runtime-loadable coefficient shift chain.
// Latency : 1 cycle from an accepted input sample to its registered result.
// Backpres: input is stalled while a result is held for the consumer or while coefficients load.
//
// Ports:
//   clk, reset_n                         - core clock, asynchronous active-low reset
//   s_axis_fir_tdata/tvalid/tready       - signed input sample stream
//   s_set_coeffs, coef_data, coef_valid  - coefficient load mode (level) and coefficient words
//   flush                                - one-cycle pulse that clears the sample delay line
//   m_axis_fir_tdata/tvalid/tready       - signed filter result stream
//
// Build option: define FIR_STREAM_SAT_EN to saturate the full-precision sum to
// Y_N_SIZE bits; otherwise the sum is truncated to its low Y_N_SIZE bits (wraps).
module fir_stream #(
    parameter int TAP_SIZE    = 4,
    parameter int NBR_OF_TAPS = 8,
    parameter int X_N_SIZE    = 8,
    parameter int Y_N_SIZE    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [X_N_SIZE-1:0] s_axis_fir_tdata,
    input  logic                       s_axis_fir_tvalid,
    output logic                       s_axis_fir_tready,
    input  logic                       s_set_coeffs,
    input  logic signed [TAP_SIZE-1:0] coef_data,
    input  logic                       coef_valid,
    input  logic                       flush,
    output logic signed [Y_N_SIZE-1:0] m_axis_fir_tdata,
    output logic                       m_axis_fir_tvalid,
    input  logic                       m_axis_fir_tready
);

    localparam int PROD_W = X_N_SIZE + TAP_SIZE;
    localparam int ACC_W  = PROD_W + $clog2(NBR_OF_TAPS);
    // Accumulate at least Y_N_SIZE wide so truncation is always a plain slice.
    localparam int EXT_W  = (ACC_W > Y_N_SIZE) ? ACC_W : Y_N_SIZE;
    localparam logic signed [TAP_SIZE-1:0] TAP_ONE = {{(TAP_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, CONFIG} state_t;

    state_t                     state_q;
    logic signed [X_N_SIZE-1:0] d_q    [NBR_OF_TAPS];
    logic signed [X_N_SIZE-1:0] d_d    [NBR_OF_TAPS];
    logic signed [TAP_SIZE-1:0] taps_q [NBR_OF_TAPS];
    logic signed [TAP_SIZE-1:0] taps_d [NBR_OF_TAPS];
    logic                       m_tvalid_q, m_tvalid_d;
    logic signed [Y_N_SIZE-1:0] m_tdata_q, m_tdata_d;
    logic signed [PROD_W-1:0]   prod;
    logic signed [EXT_W-1:0]    acc;
    logic signed [Y_N_SIZE-1:0] y_red;
    logic                       sample_hs;

    assign s_axis_fir_tready = reset_n && (state_q != CONFIG) && !s_set_coeffs
                               && (!m_tvalid_q || m_axis_fir_tready);
    assign sample_hs         = s_axis_fir_tvalid && s_axis_fir_tready;
    assign m_axis_fir_tdata  = m_tdata_q;
    assign m_axis_fir_tvalid = m_tvalid_q;

    // Delay line next state: flush clears, a handshake shifts; together the
    // new sample lands in d[0] behind an all-zero history.
    always_comb begin
        for (int i = 0; i < NBR_OF_TAPS; i++) begin
            d_d[i] = flush ? '0 : d_q[i];
        end
        if (sample_hs) begin
            d_d[0] = s_axis_fir_tdata;
            for (int i = 1; i < NBR_OF_TAPS; i++) begin
                d_d[i] = flush ? '0 : d_q[i-1];
            end
        end
    end

    // Coefficient shift chain, only advanced while in CONFIG.
    always_comb begin
        for (int i = 0; i < NBR_OF_TAPS; i++) begin
            taps_d[i] = taps_q[i];
        end
        if (state_q == CONFIG && coef_valid) begin
            taps_d[0] = coef_data;
            for (int i = 1; i < NBR_OF_TAPS; i++) begin
                taps_d[i] = taps_q[i-1];
            end
        end
    end

    // Full-precision sum over the post-shift delay line. Operands are sign
    // extended by hand so the multiply is exact at PROD_W bits.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < NBR_OF_TAPS; i++) begin
            prod = {{TAP_SIZE{d_d[i][X_N_SIZE-1]}}, d_d[i]}
                 * {{X_N_SIZE{taps_q[i][TAP_SIZE-1]}}, taps_q[i]};
            acc  = acc + {{(EXT_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

`ifdef FIR_STREAM_SAT_EN
    localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-Y_N_SIZE+1){1'b0}}, {(Y_N_SIZE-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Y_MIN = {{(EXT_W-Y_N_SIZE+1){1'b1}}, {(Y_N_SIZE-1){1'b0}}};

    always_comb begin
        if (acc > Y_MAX) begin
            y_red = Y_MAX[Y_N_SIZE-1:0];
        end else if (acc < Y_MIN) begin
            y_red = Y_MIN[Y_N_SIZE-1:0];
        end else begin
            y_red = acc[Y_N_SIZE-1:0];
        end
    end
`else
    assign y_red = acc[Y_N_SIZE-1:0];
`endif

    // Output register: a new sample always overwrites (the input is only
    // ready when the slot is free or draining); otherwise hold until taken.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        if (sample_hs) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = y_red;
        end else if (m_axis_fir_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                d_q[i]    <= '0;
                taps_q[i] <= (i == 0) ? TAP_ONE : '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_set_coeffs) begin
                        state_q <= CONFIG;
                    end else if (sample_hs) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Never leave RUN while a result is still owed downstream.
                    if (!m_tvalid_d) begin
                        if (s_set_coeffs) begin
                            state_q <= CONFIG;
                        end else if (!sample_hs) begin
                            state_q <= IDLE;
                        end
                    end
                end
                CONFIG: begin
                    if (!s_set_coeffs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                d_q[i]    <= d_d[i];
                taps_q[i] <= taps_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
// Purpose : directed self-checking bench for fir_stream (4 taps, 4-bit coefs, 8-bit in, 12-bit out).
// Latency : results are checked 1 cycle after the accepting edge.
// Backpres: downstream ready is dropped in one scenario to check hold and input stall.
module tb_fir_stream;

    localparam int TS = 4;
    localparam int NT = 4;
    localparam int XS = 8;
    localparam int YS = 12;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic signed [XS-1:0] s_tdata;
    logic                 s_tvalid;
    logic                 s_tready;
    logic                 set_c;
    logic signed [TS-1:0] coef_data;
    logic                 coef_valid;
    logic                 flush;
    logic signed [YS-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_stream #(
        .TAP_SIZE   (TS),
        .NBR_OF_TAPS(NT),
        .X_N_SIZE   (XS),
        .Y_N_SIZE   (YS)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_axis_fir_tdata (s_tdata),
        .s_axis_fir_tvalid(s_tvalid),
        .s_axis_fir_tready(s_tready),
        .s_set_coeffs     (set_c),
        .coef_data        (coef_data),
        .coef_valid       (coef_valid),
        .flush            (flush),
        .m_axis_fir_tdata (m_tdata),
        .m_axis_fir_tvalid(m_tvalid),
        .m_axis_fir_tready(m_tready)
    );

    task automatic check_eq(input string tag, input integer got, input integer exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one edge and check the registered result.
    task automatic send(input int v, input int exp, input string tag);
        s_tdata  = XS'(v);
        s_tvalid = 1'b1;
        tick();
        check_eq(tag, $signed(m_tdata), exp);
        check_eq({tag, "_vld"}, m_tvalid, 1);
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        tick();
    endtask

    // Enter CONFIG (with a competing sample offered, which must lose), shift
    // in the words in order, then return to IDLE.
    task automatic load(input int words[$], input string tag);
        set_c    = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'sd99;
        #1;
        check_eq({tag, "_prio_rdy"}, s_tready, 0);
        tick();
        check_eq({tag, "_prio_noout"}, m_tvalid, 0);
        s_tvalid = 1'b0;
        foreach (words[k]) begin
            coef_valid = 1'b1;
            coef_data  = TS'(words[k]);
            tick();
        end
        coef_valid = 1'b0;
        set_c      = 1'b0;
        tick();
    endtask

    initial begin
        int q[$];
        reset_n    = 1'b0;
        s_tdata    = 8'sh55;
        s_tvalid   = 1'b1;
        set_c      = 1'b0;
        coef_data  = '0;
        coef_valid = 1'b0;
        flush      = 1'b0;
        m_tready   = 1'b1;
        repeat (2) tick();

        // Reset state
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_tdata", $signed(m_tdata), 0);
        check_eq("rst_tready", s_tready, 0);
        s_tvalid = 1'b0;
        reset_n  = 1'b1;
        #1;
        check_eq("post_rst_tready", s_tready, 1);

        // Pass-through after reset, back-to-back
        send(5, 5, "pt0");
        send(-3, -3, "pt1");
        send(127, 127, "pt2");
        idle();
        check_eq("pt_drain", m_tvalid, 0);

        // Coefficients 1,2,3,4 -> taps [4,3,2,1]; impulse response from a clean line
        q = {1, 2, 3, 4};
        load(q, "ld1");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(1, 4, "imp0");
        send(0, 3, "imp1");
        send(0, 2, "imp2");
        send(0, 1, "imp3");
        idle();

        // Backpressure: line is [0,0,0,1]
        m_tready = 1'b0;
        send(10, 40, "bp0");        // [10,0,0,0] -> 4*10
        s_tdata = 8'sd20;
        for (int k = 0; k < 3; k++) begin
            check_eq("bp_stall_rdy", s_tready, 0);
            tick();
            check_eq("bp_hold_data", $signed(m_tdata), 40);
            check_eq("bp_hold_vld", m_tvalid, 1);
        end
        m_tready = 1'b1;
        #1;
        check_eq("bp_resume_rdy", s_tready, 1);
        send(20, 110, "bp1");       // [20,10,0,0] -> 80+30
        send(30, 200, "bp2");       // [30,20,10,0] -> 120+60+20
        idle();
        check_eq("bp_drain", m_tvalid, 0);

        // Six words: only the last four survive -> taps [0,1,0,0]
        q = {5, 5, 0, 0, 1, 0};
        load(q, "ld2");
        send(10, 30, "fl0");        // [10,30,20,10] -> d[1]
        send(20, 10, "fl1");        // [20,10,30,20] -> d[1]
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        check_eq("fl_pend_data", $signed(m_tdata), 10);
        check_eq("fl_pend_vld", m_tvalid, 1);
        m_tready = 1'b1;
        tick();
        check_eq("fl_drain", m_tvalid, 0);
        send(1, 0, "fl_after");     // [1,0,0,0]
        flush = 1'b1;
        send(7, 0, "fl_same");      // [7,0,0,0], old d[0] discarded
        flush = 1'b0;
        send(8, 7, "fl_next");      // [8,7,0,0]
        idle();

        // Large sums: taps all 7, samples -128
        q = {7, 7, 7, 7};
        load(q, "ld3");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(-128, -896, "sat0");
        send(-128, -1792, "sat1");
`ifdef FIR_STREAM_SAT_EN
        send(-128, -2048, "sat2");
        send(-128, -2048, "sat3");
`else
        send(-128, 1408, "sat2");   // -2688 + 4096
        send(-128, 512, "sat3");    // -3584 + 4096
`endif
        idle();

        // Reset mid-CONFIG after two words
        set_c = 1'b1;
        tick();
        coef_valid = 1'b1;
        coef_data  = 4'sd3;
        tick();
        coef_data  = 4'sd2;
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("cfg_rst_vld", m_tvalid, 0);
        check_eq("cfg_rst_rdy", s_tready, 0);
        check_eq("cfg_rst_data", $signed(m_tdata), 0);
        coef_valid = 1'b0;
        set_c      = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        send(9, 9, "cfg_rst_pt");

        // coef_valid outside CONFIG must not move the taps
        s_tvalid   = 1'b0;
        coef_valid = 1'b1;
        coef_data  = 4'sd5;
        tick();
        coef_valid = 1'b0;
        send(4, 4, "cv_ignored");   // [4,9,0,0] pass-through
        idle();
        check_eq("end_drain", m_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
